id_ex_stage_reg: RTL and testbench
==================================

// Module: id_ex_stage_reg
// PURPOSE
//  ID/EX pipeline register of the 5-stage MIPS core with integrated load-use hazard detection.
//  Captures decoded control, register operands, immediate and rs/rt/rd indices from ID.
//  Drives EX and supplies id_ex_rs/id_ex_rt to the forwarding unit.
//  Inserts bubbles on load-use hazards and branch flushes; holds on memory stall.
// PARAMETERS
//  DATA_W   32  operand / immediate width
//  REG_AW   5   register index width
//  ALUOP_W  3   ALU op field width
//  CNT_W    16  width of the saturating bubble counter
// PORTS
//  clk             in   1        rising-edge clock
//  rst_n           in   1        asynchronous active-low reset
//  if_id_valid     in   1        ID holds a real instruction
//  if_id_rs        in   REG_AW   source 1 index
//  if_id_rt        in   REG_AW   source 2 index
//  if_id_rd        in   REG_AW   R-type destination index
//  id_rd1, id_rd2  in   DATA_W   register-file read data
//  id_imm          in   DATA_W   sign-extended immediate
//  id_ctrl         in   8+ALUOP_W  {regWrite,memRead,memWrite,memToReg,aluSrc,regDst,branch,jump,aluOp}
//  flush           in   1        branch/jump resolved taken in EX; kill ID instruction
//  mem_stall       in   1        data memory busy; freeze the whole front end
//  id_ex_*         out  -        registered copies of all ID inputs (valid, rs, rt, rd, rd1, rd2, imm, ctrl)
//  pc_write        out  1        PC may advance
//  if_id_write     out  1        IF/ID may load
//  hazard_stall    out  1        load-use bubble being inserted this cycle
//  bubble_cnt      out  CNT_W    total bubbles inserted, saturating
// BEHAVIOUR
//  Reset (async, rst_n=0): every id_ex_* output and bubble_cnt = 0. id_ex_valid=0, so the
//   register holds a NOP. Reset in mid-operation discards the held instruction immediately.
//  Load-use detect (combinational on current ID/EX contents):
//   lu = id_ex_valid & id_ex_ctrl.memRead & (id_ex_rt != 0) & if_id_valid
//        & (id_ex_rt == if_id_rs | id_ex_rt == if_id_rt).
//  Per-cycle priority, highest first:
//   1 mem_stall=1: ID/EX holds its contents; pc_write=0, if_id_write=0, hazard_stall=0.
//   2 flush=1: load a bubble (valid=0, all ctrl=0, data fields don't-care but zeroed);
//     pc_write=1, if_id_write=1 (fetch of the redirected PC proceeds); bubble_cnt++.
//     flush takes priority over lu.
//   3 lu=1: load a bubble; pc_write=0, if_id_write=0, hazard_stall=1; bubble_cnt++.
//   4 otherwise: load the ID inputs; pc_write=1, if_id_write=1.
//  A bubble is a true NOP: regWrite=memWrite=memRead=branch=jump=0. This keeps the forwarding
//   unit and memory stage inert.
//  A load followed by a dependent instruction gives exactly one bubble. On the next cycle
//   ID/EX holds the bubble, so lu=0 and the dependent instruction advances. EX/MEM forwarding
//   then resolves the dependency.
//  Back-to-back loads into the same dependent instruction: each stall is evaluated fresh.
//   There is no stall-state carry-over.
//  pc_write, if_id_write and hazard_stall are combinational (zero latency).
//   All id_ex_* outputs change only on the clock edge (1-cycle latency).
//  bubble_cnt: increments by 1 per bubble cycle and holds at all-ones when saturated.
//   It does not change during mem_stall.
//  if_id_valid=0 never triggers lu. It is copied into id_ex_valid with ctrl forced to 0.
// STRUCTURE
//  Shared package pipe_pkg holds:
//   - ctrl_t packed struct (field order as in id_ctrl)
//   - CTRL_NOP constant
//   - REG_ZERO constant
//  One sub-module, load_use_detect, is combinational and produces lu. All registers and
//   priority muxing stay in the top.
// TESTING
//  T1 rst_n low mid-run with id_ex_valid=1 -> all id_ex_* outputs and bubble_cnt read 0
//     asynchronously, before the next edge.
//  T2 lw $8 then add $9,$8,$3 -> one cycle with hazard_stall=1, pc_write=0, id_ex_ctrl=NOP.
//     Next cycle the add is in ID/EX with id_ex_rs=8; bubble_cnt=1.
//  T3 lw $0 then add $9,$0,$3 -> no stall (rt=0 exempt); add enters ID/EX next cycle.
//  T4 flush=1 together with a load-use condition -> bubble loaded, pc_write=1, hazard_stall=0.
//     bubble_cnt increments once.
//  T5 mem_stall=1 for 3 cycles while a load-use is pending -> ID/EX contents unchanged,
//     pc_write=0, bubble_cnt unchanged. After release the single bubble is inserted.
//  T6 force bubble_cnt to 16'hFFFE, then insert 3 bubbles -> reads 16'hFFFF and stays there.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared ID/EX control layout, NOP constant and stage action encoding
package pipe_pkg;

  localparam int ALU_OP_BITS  = 3;
  localparam int REG_IDX_BITS = 5;

  typedef struct packed {
    logic                   reg_write;
    logic                   mem_read;
    logic                   mem_write;
    logic                   mem_to_reg;
    logic                   alu_src;
    logic                   reg_dst;
    logic                   branch;
    logic                   jump;
    logic [ALU_OP_BITS-1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t                   CTRL_NOP = '0;
  localparam logic [REG_IDX_BITS-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    ACT_LOAD   = 2'd0,
    ACT_BUBBLE = 2'd1,
    ACT_HOLD   = 2'd2
  } act_e;

  // alu_op occupies the low bits of the control word, so mem_read sits 6 above it
  function automatic int mem_read_bit(input int aluop_w);
    return aluop_w + 6;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard between ID/EX load and the ID instruction
module load_use_detect
  import pipe_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              id_ex_valid,
  input  logic              id_ex_mem_read,
  input  logic [REG_AW-1:0] id_ex_rt,
  input  logic              if_id_valid,
  input  logic [REG_AW-1:0] if_id_rs,
  input  logic [REG_AW-1:0] if_id_rt,
  output logic              lu
);

  logic rt_nonzero;
  logic src_match;

  // $0 is hard-wired, so a load targeting it can never create a real dependency
  assign rt_nonzero = (id_ex_rt != REG_AW'(REG_ZERO));
  assign src_match  = (id_ex_rt == if_id_rs) | (id_ex_rt == if_id_rt);
  assign lu         = id_ex_valid & id_ex_mem_read & rt_nonzero & if_id_valid & src_match;

endmodule

// File: rtl/id_ex_stage_reg.sv
// rtl/id_ex_stage_reg.sv - ID/EX pipeline register with load-use bubble insertion, flush and memory-stall hold
module id_ex_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 3,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 if_id_valid,
  input  logic [REG_AW-1:0]    if_id_rs,
  input  logic [REG_AW-1:0]    if_id_rt,
  input  logic [REG_AW-1:0]    if_id_rd,
  input  logic [DATA_W-1:0]    id_rd1,
  input  logic [DATA_W-1:0]    id_rd2,
  input  logic [DATA_W-1:0]    id_imm,
  input  logic [8+ALUOP_W-1:0] id_ctrl,
  input  logic                 flush,
  input  logic                 mem_stall,
  output logic                 id_ex_valid,
  output logic [REG_AW-1:0]    id_ex_rs,
  output logic [REG_AW-1:0]    id_ex_rt,
  output logic [REG_AW-1:0]    id_ex_rd,
  output logic [DATA_W-1:0]    id_ex_rd1,
  output logic [DATA_W-1:0]    id_ex_rd2,
  output logic [DATA_W-1:0]    id_ex_imm,
  output logic [8+ALUOP_W-1:0] id_ex_ctrl,
  output logic                 pc_write,
  output logic                 if_id_write,
  output logic                 hazard_stall,
  output logic [CNT_W-1:0]     bubble_cnt
);

  localparam int                CTRL_W       = 8 + ALUOP_W;
  localparam int                MEM_READ_IDX = mem_read_bit(ALUOP_W);
  localparam logic [CTRL_W-1:0] BUBBLE_CTRL  = CTRL_W'(CTRL_NOP);

  logic lu;
  act_e act;

  load_use_detect #(
    .REG_AW(REG_AW)
  ) u_load_use_detect (
    .id_ex_valid   (id_ex_valid),
    .id_ex_mem_read(id_ex_ctrl[MEM_READ_IDX]),
    .id_ex_rt      (id_ex_rt),
    .if_id_valid   (if_id_valid),
    .if_id_rs      (if_id_rs),
    .if_id_rt      (if_id_rt),
    .lu            (lu)
  );

  always_comb begin
    act          = ACT_LOAD;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    hazard_stall = 1'b0;
    if (mem_stall) begin
      act         = ACT_HOLD;
      pc_write    = 1'b0;
      if_id_write = 1'b0;
    end else if (flush) begin
      // the redirected fetch must proceed, so the front end keeps moving
      act = ACT_BUBBLE;
    end else if (lu) begin
      act          = ACT_BUBBLE;
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      hazard_stall = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex_valid <= 1'b0;
      id_ex_rs    <= '0;
      id_ex_rt    <= '0;
      id_ex_rd    <= '0;
      id_ex_rd1   <= '0;
      id_ex_rd2   <= '0;
      id_ex_imm   <= '0;
      id_ex_ctrl  <= BUBBLE_CTRL;
    end else begin
      case (act)
        ACT_LOAD: begin
          id_ex_valid <= if_id_valid;
          id_ex_rs    <= if_id_rs;
          id_ex_rt    <= if_id_rt;
          id_ex_rd    <= if_id_rd;
          id_ex_rd1   <= id_rd1;
          id_ex_rd2   <= id_rd2;
          id_ex_imm   <= id_imm;
          id_ex_ctrl  <= if_id_valid ? id_ctrl : BUBBLE_CTRL;
        end
        ACT_BUBBLE: begin
          id_ex_valid <= 1'b0;
          id_ex_rs    <= '0;
          id_ex_rt    <= '0;
          id_ex_rd    <= '0;
          id_ex_rd1   <= '0;
          id_ex_rd2   <= '0;
          id_ex_imm   <= '0;
          id_ex_ctrl  <= BUBBLE_CTRL;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
    end else if (act == ACT_BUBBLE && bubble_cnt != {CNT_W{1'b1}}) begin
      bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb/tb_id_ex_stage_reg.sv - vector table and scoreboard bench for id_ex_stage_reg
module tb_id_ex_stage_reg;
  import pipe_pkg::*;

  localparam int K_LOAD = 0;
  localparam int K_BUB  = 1;
  localparam int K_HOLD = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_id_valid = 1'b0;
  logic [4:0]  if_id_rs = '0, if_id_rt = '0, if_id_rd = '0;
  logic [31:0] id_rd1 = '0, id_rd2 = '0, id_imm = '0;
  logic [10:0] id_ctrl = '0;
  logic        flush = 1'b0, mem_stall = 1'b0;
  logic        id_ex_valid;
  logic [4:0]  id_ex_rs, id_ex_rt, id_ex_rd;
  logic [31:0] id_ex_rd1, id_ex_rd2, id_ex_imm;
  logic [10:0] id_ex_ctrl;
  logic        pc_write, if_id_write, hazard_stall;
  logic [15:0] bubble_cnt;

  id_ex_stage_reg dut (
    .clk(clk), .rst_n(rst_n), .if_id_valid(if_id_valid), .if_id_rs(if_id_rs),
    .if_id_rt(if_id_rt), .if_id_rd(if_id_rd), .id_rd1(id_rd1), .id_rd2(id_rd2),
    .id_imm(id_imm), .id_ctrl(id_ctrl), .flush(flush), .mem_stall(mem_stall),
    .id_ex_valid(id_ex_valid), .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd),
    .id_ex_rd1(id_ex_rd1), .id_ex_rd2(id_ex_rd2), .id_ex_imm(id_ex_imm), .id_ex_ctrl(id_ex_ctrl),
    .pc_write(pc_write), .if_id_write(if_id_write), .hazard_stall(hazard_stall),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rd1;
    logic [10:0] ctrl;
    logic        fl, st;
    logic        pcw, hz;
    int          kind;
  } vec_t;

  typedef logic [122:0] data_t;
  typedef logic [138:0] snap_t;

  vec_t        vecs[$];
  snap_t       sb_q[$];
  data_t       m_data;
  logic [15:0] m_cnt;
  int          passed = 0;
  int          total = 0;

  function automatic logic [10:0] lw_ctrl();
    ctrl_t c;
    c = CTRL_NOP;
    c.reg_write  = 1'b1;
    c.mem_read   = 1'b1;
    c.mem_to_reg = 1'b1;
    c.alu_src    = 1'b1;
    return c;
  endfunction

  function automatic logic [10:0] add_ctrl();
    ctrl_t c;
    c = CTRL_NOP;
    c.reg_write = 1'b1;
    c.reg_dst   = 1'b1;
    c.alu_op    = 3'b010;
    return c;
  endfunction

  function automatic vec_t mkv(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic [31:0] rd1, input logic [10:0] ctrl,
                               input logic fl, input logic st, input logic pcw, input logic hz,
                               input int kind);
    vec_t r;
    r.v = v; r.rs = rs; r.rt = rt; r.rd = rd; r.rd1 = rd1; r.ctrl = ctrl;
    r.fl = fl; r.st = st; r.pcw = pcw; r.hz = hz; r.kind = kind;
    return r;
  endfunction

  function automatic snap_t dut_snap();
    return {id_ex_valid, id_ex_rs, id_ex_rt, id_ex_rd, id_ex_rd1, id_ex_rd2, id_ex_imm,
            id_ex_ctrl, bubble_cnt};
  endfunction

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h expected=%h", name, act, exp);
  endtask

  task automatic apply(input vec_t v, input int idx);
    data_t d;
    logic [15:0] c;
    snap_t got;
    @(negedge clk);
    if_id_valid = v.v; if_id_rs = v.rs; if_id_rt = v.rt; if_id_rd = v.rd;
    id_rd1 = v.rd1; id_rd2 = v.rd1 ^ 32'h5A5A_0000; id_imm = v.rd1 + 32'd1;
    id_ctrl = v.ctrl; flush = v.fl; mem_stall = v.st;
    #1;
    check($sformatf("comb[%0d] pcw/ifw/hz", idx), {pc_write, if_id_write, hazard_stall},
          {v.pcw, v.pcw, v.hz});
    c = m_cnt;
    case (v.kind)
      K_LOAD:  d = {v.v, v.rs, v.rt, v.rd, v.rd1, v.rd1 ^ 32'h5A5A_0000, v.rd1 + 32'd1,
                    v.v ? v.ctrl : 11'd0};
      K_BUB: begin
        d = '0;
        if (c != 16'hFFFF) c = c + 16'd1;
      end
      default: d = m_data;
    endcase
    sb_q.push_back({d, c});
    m_data = d;
    m_cnt  = c;
    @(posedge clk);
    #1;
    got = dut_snap();
    check($sformatf("id_ex[%0d]", idx), got, sb_q.pop_front());
  endtask

  initial begin
    m_data = '0;
    m_cnt  = '0;
    // lw/add dependency, rt=0 exemption, flush over load-use, stall hold, invalid ID, rt-side match
    vecs.push_back(mkv(1, 2, 8, 0, 32'h100, lw_ctrl(),  0, 0, 1, 0, K_LOAD));
    vecs.push_back(mkv(1, 8, 3, 9, 32'h200, add_ctrl(), 0, 0, 0, 1, K_BUB));
    vecs.push_back(mkv(1, 8, 3, 9, 32'h200, add_ctrl(), 0, 0, 1, 0, K_LOAD));
    vecs.push_back(mkv(1, 4, 0, 0, 32'h300, lw_ctrl(),  0, 0, 1, 0, K_LOAD));
    vecs.push_back(mkv(1, 0, 3, 9, 32'h400, add_ctrl(), 0, 0, 1, 0, K_LOAD));
    vecs.push_back(mkv(1, 1, 8, 0, 32'h500, lw_ctrl(),  0, 0, 1, 0, K_LOAD));
    vecs.push_back(mkv(1, 3, 8, 9, 32'h600, add_ctrl(), 1, 0, 1, 0, K_BUB));
    vecs.push_back(mkv(1, 1, 5, 0, 32'h700, lw_ctrl(),  0, 0, 1, 0, K_LOAD));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mkv(1, 5, 6, 7, 32'h800, add_ctrl(), 0, 1, 0, 0, K_HOLD));
    vecs.push_back(mkv(1, 5, 6, 7, 32'h800, add_ctrl(), 0, 0, 0, 1, K_BUB));
    vecs.push_back(mkv(1, 5, 6, 7, 32'h800, add_ctrl(), 0, 0, 1, 0, K_LOAD));
    vecs.push_back(mkv(0, 7, 9, 0, 32'h900, lw_ctrl(),  0, 0, 1, 0, K_LOAD));
    vecs.push_back(mkv(1, 0, 6, 0, 32'hA00, lw_ctrl(),  0, 0, 1, 0, K_LOAD));
    vecs.push_back(mkv(0, 6, 6, 0, 32'hB00, add_ctrl(), 0, 0, 1, 0, K_LOAD));
    vecs.push_back(mkv(1, 0, 6, 0, 32'hC00, lw_ctrl(),  0, 0, 1, 0, K_LOAD));
    vecs.push_back(mkv(1, 6, 7, 0, 32'hD00, lw_ctrl(),  0, 0, 0, 1, K_BUB));
    vecs.push_back(mkv(1, 6, 7, 0, 32'hD00, lw_ctrl(),  0, 0, 1, 0, K_LOAD));
    vecs.push_back(mkv(1, 1, 7, 9, 32'hE00, add_ctrl(), 0, 0, 0, 1, K_BUB));
    vecs.push_back(mkv(1, 1, 7, 9, 32'hE00, add_ctrl(), 0, 0, 1, 0, K_LOAD));
    vecs.push_back(mkv(1, 9, 9, 0, 32'hF00, lw_ctrl(),  1, 1, 0, 0, K_HOLD));
    vecs.push_back(mkv(1, 9, 9, 0, 32'hF00, lw_ctrl(),  0, 0, 1, 0, K_LOAD));

    #12;
    check("reset_state", dut_snap(), '0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // asynchronous reset while a valid instruction is held
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_midrun", dut_snap(), '0);
    @(negedge clk);
    rst_n = 1'b1;
    m_data = '0;
    m_cnt  = '0;

    // drive the counter to one below saturation with flush bubbles
    if_id_valid = 1'b1; if_id_rs = 5'd1; if_id_rt = 5'd2; id_ctrl = lw_ctrl();
    flush = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    check("bubble_cnt_fffe", bubble_cnt, 16'hFFFE);
    flush = 1'b0;
    m_data = '0;
    m_cnt  = 16'hFFFE;
    for (int i = 0; i < 3; i++)
      apply(mkv(1, 1, 2, 0, 32'h1234, lw_ctrl(), 1, 0, 1, 0, K_BUB), 100 + i);
    check("bubble_cnt_saturated", bubble_cnt, 16'hFFFF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
